// File: rtl/sb_reg_access_ctrl.sv
// Sideband register-access controller: decodes deframed read/write commands into
// register-file strobes and returns read data, a write echo or a 0xFF error status.
module sb_reg_access_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned REG_DEPTH   = 157
) (
    input  logic        fsm_clk,
    input  logic        rst,
    input  logic [7:0]  cmd_byte,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic        s_read,
    output logic        s_write,
    output logic [7:0]  s_address,
    output logic [7:0]  s_data,
    input  logic [23:0] sb_read,
    output logic [7:0]  rsp_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_last
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_ADDR,
        ST_WDATA,
        ST_WSTB,
        ST_RD_REQ,
        ST_RD_CAP,
        ST_RSP
    } state_t;

    localparam logic [15:0] LP_TMO_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [9:0]  LP_DEPTH    = 10'(REG_DEPTH);
    localparam logic [7:0]  LP_ERR_RSP  = 8'hFF;

    state_t      r_state,     w_state;
    logic [7:0]  r_hdr,       w_hdr;
    logic [7:0]  r_addr,      w_addr;
    logic        r_err,       w_err;
    logic [1:0]  r_idx,       w_idx;
    logic [15:0] r_tmo,       w_tmo;
    logic [23:0] r_rd_data,   w_rd_data;
    logic [1:0]  r_rsp_idx,   w_rsp_idx;
    logic        r_s_read,    w_s_read;
    logic        r_s_write,   w_s_write;
    logic [7:0]  r_s_address, w_s_address;
    logic [7:0]  r_s_data,    w_s_data;
    logic [7:0]  r_rsp_data,  w_rsp_data;
    logic        r_rsp_valid, w_rsp_valid;
    logic        r_rsp_last,  w_rsp_last;

    logic        w_cmd_ready;
    logic        w_cmd_acc;
    logic        w_rsp_acc;
    logic [1:0]  w_hdr_len;
    logic        w_legal_wr;
    logic        w_legal_rd;
    logic [8:0]  w_last_addr;
    logic        w_range_err;
    logic        w_last_data;
    logic        w_tmo_hit;

    assign w_cmd_ready = (r_state == ST_IDLE) || (r_state == ST_HDR_ADDR) || (r_state == ST_WDATA);
    assign w_cmd_acc   = cmd_valid & w_cmd_ready;
    assign w_rsp_acc   = r_rsp_valid & rsp_ready;

    assign w_hdr_len   = r_hdr[1:0];
    assign w_legal_wr  = r_hdr[7] & ~(|r_hdr[6:2]) & (w_hdr_len != 2'd0);
    assign w_legal_rd  = (r_hdr == 8'h00);
    // Last touched address in 9 bits so a range crossing 0xFF cannot wrap back in range
    assign w_last_addr = r_hdr[7] ? ({1'b0, cmd_byte} + {7'b0, w_hdr_len} - 9'd1)
                                  : {1'b0, cmd_byte};
    assign w_range_err = ({1'b0, w_last_addr} >= LP_DEPTH);
    assign w_last_data = (r_idx == (w_hdr_len - 2'd1));
    assign w_tmo_hit   = (r_tmo == LP_TMO_LAST);

    always_comb begin
        w_state     = r_state;
        w_hdr       = r_hdr;
        w_addr      = r_addr;
        w_err       = r_err;
        w_idx       = r_idx;
        w_tmo       = r_tmo;
        w_rd_data   = r_rd_data;
        w_rsp_idx   = r_rsp_idx;
        w_s_read    = 1'b0;
        w_s_write   = 1'b0;
        w_s_address = r_s_address;
        w_s_data    = r_s_data;
        w_rsp_data  = r_rsp_data;
        w_rsp_valid = r_rsp_valid;
        w_rsp_last  = r_rsp_last;

        case (r_state)
            ST_IDLE: begin
                if (w_cmd_acc) begin
                    w_hdr   = cmd_byte;
                    w_tmo   = '0;
                    w_state = ST_HDR_ADDR;
                end
            end

            ST_HDR_ADDR: begin
                if (w_cmd_acc) begin
                    w_addr = cmd_byte;
                    w_tmo  = '0;
                    w_idx  = '0;
                    if (w_legal_wr) begin
                        w_err   = w_range_err;
                        w_state = ST_WDATA;
                    end else if (w_legal_rd && !w_range_err) begin
                        w_s_read    = 1'b1;
                        w_s_address = cmd_byte;
                        w_state     = ST_RD_REQ;
                    end else begin
                        w_rsp_data  = LP_ERR_RSP;
                        w_rsp_valid = 1'b1;
                        w_rsp_last  = 1'b1;
                        w_state     = ST_RSP;
                    end
                end else if (w_tmo_hit) begin
                    w_tmo       = '0;
                    w_rsp_data  = LP_ERR_RSP;
                    w_rsp_valid = 1'b1;
                    w_rsp_last  = 1'b1;
                    w_state     = ST_RSP;
                end else begin
                    w_tmo = r_tmo + 16'd1;
                end
            end

            ST_WDATA: begin
                if (w_cmd_acc) begin
                    w_tmo = '0;
                    if (r_err) begin
                        // Erroneous write: swallow the data bytes, answer once all are in
                        if (w_last_data) begin
                            w_rsp_data  = LP_ERR_RSP;
                            w_rsp_valid = 1'b1;
                            w_rsp_last  = 1'b1;
                            w_state     = ST_RSP;
                        end else begin
                            w_idx = r_idx + 2'd1;
                        end
                    end else begin
                        w_s_write   = 1'b1;
                        w_s_address = r_addr + {6'b0, r_idx};
                        w_s_data    = cmd_byte;
                        w_state     = ST_WSTB;
                    end
                end else if (w_tmo_hit) begin
                    w_tmo       = '0;
                    w_rsp_data  = LP_ERR_RSP;
                    w_rsp_valid = 1'b1;
                    w_rsp_last  = 1'b1;
                    w_state     = ST_RSP;
                end else begin
                    w_tmo = r_tmo + 16'd1;
                end
            end

            ST_WSTB: begin
                if (w_last_data) begin
                    w_rsp_data  = r_hdr;
                    w_rsp_valid = 1'b1;
                    w_rsp_last  = 1'b1;
                    w_state     = ST_RSP;
                end else begin
                    w_idx   = r_idx + 2'd1;
                    w_state = ST_WDATA;
                end
            end

            ST_RD_REQ: begin
                w_state = ST_RD_CAP;
            end

            ST_RD_CAP: begin
                w_rd_data   = sb_read;
                w_rsp_idx   = '0;
                w_rsp_data  = 8'h00;
                w_rsp_valid = 1'b1;
                w_rsp_last  = 1'b0;
                w_state     = ST_RSP;
            end

            ST_RSP: begin
                if (w_rsp_acc) begin
                    if (r_rsp_last) begin
                        w_rsp_data  = '0;
                        w_rsp_valid = 1'b0;
                        w_rsp_last  = 1'b0;
                        w_state     = ST_IDLE;
                    end else begin
                        w_rsp_idx  = r_rsp_idx + 2'd1;
                        w_rsp_last = (r_rsp_idx == 2'd2);
                        case (r_rsp_idx)
                            2'd0:    w_rsp_data = r_rd_data[7:0];
                            2'd1:    w_rsp_data = r_rd_data[15:8];
                            default: w_rsp_data = r_rd_data[23:16];
                        endcase
                    end
                end
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge fsm_clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_hdr       <= '0;
            r_addr      <= '0;
            r_err       <= 1'b0;
            r_idx       <= '0;
            r_tmo       <= '0;
            r_rd_data   <= '0;
            r_rsp_idx   <= '0;
            r_s_read    <= 1'b0;
            r_s_write   <= 1'b0;
            r_s_address <= '0;
            r_s_data    <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_hdr       <= w_hdr;
            r_addr      <= w_addr;
            r_err       <= w_err;
            r_idx       <= w_idx;
            r_tmo       <= w_tmo;
            r_rd_data   <= w_rd_data;
            r_rsp_idx   <= w_rsp_idx;
            r_s_read    <= w_s_read;
            r_s_write   <= w_s_write;
            r_s_address <= w_s_address;
            r_s_data    <= w_s_data;
            r_rsp_data  <= w_rsp_data;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_last  <= w_rsp_last;
        end
    end

    assign cmd_ready = w_cmd_ready;
    assign s_read    = r_s_read;
    assign s_write   = r_s_write;
    assign s_address = r_s_address;
    assign s_data    = r_s_data;
    assign rsp_data  = r_rsp_data;
    assign rsp_valid = r_rsp_valid;
    assign rsp_last  = r_rsp_last;

endmodule

// File: tb/tb_sb_reg_access_ctrl.sv
// Bench for sb_reg_access_ctrl: directed and random commands checked against a
// command-level reference model, with a small register file answering reads.
module tb_sb_reg_access_ctrl;

    localparam int unsigned TMO   = 8;
    localparam int unsigned DEPTH = 157;

    logic        fsm_clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  cmd_byte = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        s_read, s_write;
    logic [7:0]  s_address, s_data;
    logic [23:0] sb_read = '0;
    logic [7:0]  rsp_data;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_last;

    sb_reg_access_ctrl #(.TIMEOUT_CYC(TMO), .REG_DEPTH(DEPTH)) dut (
        .fsm_clk(fsm_clk), .rst(rst),
        .cmd_byte(cmd_byte), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .s_read(s_read), .s_write(s_write), .s_address(s_address), .s_data(s_data),
        .sb_read(sb_read),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_last(rsp_last)
    );

    always #5 fsm_clk = ~fsm_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int viol = 0;

    typedef struct {
        bit         wr;
        logic [7:0] a;
        logic [7:0] d;
        int         c;
    } strobe_t;

    strobe_t     obs_q[$];
    strobe_t     exp_q[$];
    int          rise_q[$];
    logic [7:0]  got_q[$];
    bit          got_last[$];
    logic [23:0] ref_mem[256];
    bit [7:0]    rf_lo[256];
    bit          rf_wr[256];
    logic [23:0] rf_q;
    bit          prev_stb = 1'b0;
    bit          prev_rv = 1'b0;

    function automatic logic [23:0] reset_val(input logic [7:0] a);
        if (a == 8'h4E) return 24'h053303;
        return {a ^ 8'hC3, ~a, a + 8'h11};
    endfunction

    always @(posedge fsm_clk) cyc <= cyc + 1;

    // Register file environment: read data appears the cycle after s_read
    always_comb begin
        rf_q = reset_val(s_address);
        if (rf_wr[s_address]) rf_q[7:0] = rf_lo[s_address];
    end

    always @(posedge fsm_clk) begin
        if (s_write) begin
            rf_lo[s_address] <= s_data;
            rf_wr[s_address] <= 1'b1;
        end
        if (s_read) sb_read <= rf_q;
    end

    always @(negedge fsm_clk) begin
        if (s_write || s_read) obs_q.push_back('{s_write, s_address, s_data, cyc});
        if ((s_write && s_read) || ((s_write || s_read) && prev_stb)) viol <= viol + 1;
        prev_stb <= s_write || s_read;
        if (rsp_valid && !prev_rv) rise_q.push_back(cyc);
        prev_rv <= rsp_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_s_read"},    32'(s_read),    32'd0);
        check({tag, "_s_write"},   32'(s_write),   32'd0);
        check({tag, "_s_address"}, 32'(s_address), 32'd0);
        check({tag, "_s_data"},    32'(s_data),    32'd0);
        check({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_last"},  32'(rsp_last),  32'd0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok, output int acc_c);
        ok = 1'b0;
        cmd_byte = b;
        cmd_valid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge fsm_clk);
            if (cmd_ready) ok = 1'b1;
            @(posedge fsm_clk);
            #1;
        end
        acc_c = cyc;
        cmd_valid = 1'b0;
        cmd_byte = '0;
    endtask

    task automatic recv_rsp(output bit done);
        done = 1'b0;
        got_q.delete();
        got_last.delete();
        for (int n = 0; n < 300 && !done; n++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge fsm_clk);
            if (rsp_valid && rsp_ready) begin
                got_q.push_back(rsp_data);
                got_last.push_back(rsp_last);
                if (rsp_last) done = 1'b1;
            end
            @(posedge fsm_clk);
            #1;
        end
        rsp_ready = 1'b0;
    endtask

    // Sends one command (optionally truncated to nsend_req bytes) and checks strobes,
    // their cycles, the response bytes and the response start cycle.
    task automatic run_cmd(input logic [7:0] hdr, input logic [7:0] addr,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           input int nsend_req, input bit bp);
        logic [7:0]  dat[3];
        logic [7:0]  exp_rsp[$];
        logic [7:0]  b, hold_d;
        logic [23:0] m;
        int          len, last_a, need, nsend, acc_c, exp_rise, w;
        bit          legal_wr, legal_rd, err, ok, done, hold_l;

        dat[0] = d0; dat[1] = d1; dat[2] = d2;
        len      = int'(hdr[1:0]);
        legal_wr = hdr[7] && (hdr[6:2] == 5'd0) && (len != 0);
        legal_rd = (hdr == 8'h00);
        last_a   = legal_wr ? int'(addr) + len - 1 : int'(addr);
        err      = !(legal_wr || legal_rd) || (last_a >= int'(DEPTH));
        need     = legal_wr ? 2 + len : 2;
        nsend    = (nsend_req < 1 || nsend_req > need) ? need : nsend_req;

        exp_q.delete();
        obs_q.delete();
        rise_q.delete();
        acc_c = 0;
        for (int i = 0; i < nsend; i++) begin
            b = (i == 0) ? hdr : (i == 1) ? addr : dat[i - 2];
            repeat ($urandom_range(0, 2)) begin
                @(posedge fsm_clk);
                #1;
            end
            send_byte(b, ok, acc_c);
            check("cmd_accept", 32'(ok), 32'd1);
            if (!ok) return;
            if (!err && nsend == need) begin
                if (legal_rd && i == 1) exp_q.push_back('{1'b0, addr, 8'h00, acc_c});
                if (legal_wr && i >= 2) exp_q.push_back('{1'b1, 8'(int'(addr) + i - 2), dat[i - 2], acc_c});
            end
        end

        if (nsend < need) begin
            exp_rsp.push_back(8'hFF);
            exp_rise = acc_c + int'(TMO);
        end else if (err) begin
            exp_rsp.push_back(8'hFF);
            exp_rise = acc_c;
        end else if (legal_wr) begin
            exp_rsp.push_back(hdr);
            exp_rise = acc_c + 1;
            for (int i = 0; i < len; i++) ref_mem[8'(int'(addr) + i)][7:0] = dat[i];
        end else begin
            m = ref_mem[addr];
            exp_rsp.push_back(8'h00);
            exp_rsp.push_back(m[7:0]);
            exp_rsp.push_back(m[15:8]);
            exp_rsp.push_back(m[23:16]);
            exp_rise = acc_c + 2;
        end

        if (bp) begin
            w = 0;
            while (!rsp_valid && w < 20) begin
                @(posedge fsm_clk);
                #1;
                w++;
            end
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            hold_d = rsp_data;
            hold_l = rsp_last;
            repeat (10) begin
                @(negedge fsm_clk);
                check("bp_hold_data",  32'(rsp_data),  32'(hold_d));
                check("bp_hold_valid", 32'(rsp_valid), 32'd1);
                check("bp_hold_last",  32'(rsp_last),  32'(hold_l));
                check("bp_cmd_ready",  32'(cmd_ready), 32'd0);
                @(posedge fsm_clk);
                #1;
            end
        end

        recv_rsp(done);
        check("rsp_complete", 32'(done), 32'd1);
        check("rsp_len", 32'(got_q.size()), 32'(exp_rsp.size()));
        for (int i = 0; i < got_q.size() && i < exp_rsp.size(); i++) begin
            check("rsp_byte", 32'(got_q[i]), 32'(exp_rsp[i]));
            check("rsp_last", 32'(got_last[i]), 32'(i == exp_rsp.size() - 1));
        end
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_cmd_ready", 32'(cmd_ready), 32'd1);

        check("strobe_count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check("strobe_kind",  32'(obs_q[i].wr), 32'(exp_q[i].wr));
            check("strobe_addr",  32'(obs_q[i].a),  32'(exp_q[i].a));
            check("strobe_cycle", 32'(obs_q[i].c),  32'(exp_q[i].c));
            if (exp_q[i].wr) check("strobe_data", 32'(obs_q[i].d), 32'(exp_q[i].d));
        end
        check("rsp_rise_count", 32'(rise_q.size()), 32'd1);
        if (rise_q.size() > 0) check("rsp_rise_cycle", 32'(rise_q[0]), 32'(exp_rise));
    endtask

    initial begin
        bit ok;
        int acc_c;
        logic [7:0] h, a;
        int sel, ns;

        for (int i = 0; i < 256; i++) ref_mem[i] = reset_val(8'(i));

        repeat (3) @(posedge fsm_clk);
        #1;
        check_outputs_zero("in_reset");
        rst = 1'b1;
        @(posedge fsm_clk);
        #1;
        check_outputs_zero("after_reset");

        run_cmd(8'h00, 8'h4E, 8'h00, 8'h00, 8'h00, -1, 1'b0);
        run_cmd(8'h82, 8'h55, 8'h11, 8'h22, 8'h00, -1, 1'b0);
        run_cmd(8'h82, 8'h9C, 8'hAA, 8'hBB, 8'h00, -1, 1'b0);
        run_cmd(8'h81, 8'h10, 8'h00, 8'h00, 8'h00, 1, 1'b0);
        run_cmd(8'h00, 8'h4E, 8'h00, 8'h00, 8'h00, -1, 1'b0);
        run_cmd(8'h00, 8'h4E, 8'h00, 8'h00, 8'h00, -1, 1'b1);

        run_cmd(8'h00, 8'h9C, 8'h00, 8'h00, 8'h00, -1, 1'b0);
        run_cmd(8'h00, 8'h9D, 8'h00, 8'h00, 8'h00, -1, 1'b0);
        run_cmd(8'h83, 8'h9A, 8'h01, 8'h02, 8'h03, -1, 1'b0);
        run_cmd(8'h00, 8'h9B, 8'h00, 8'h00, 8'h00, -1, 1'b0);
        run_cmd(8'h83, 8'hFF, 8'h01, 8'h02, 8'h03, -1, 1'b0);
        run_cmd(8'h01, 8'h10, 8'h00, 8'h00, 8'h00, -1, 1'b0);
        run_cmd(8'h80, 8'h10, 8'h00, 8'h00, 8'h00, -1, 1'b0);
        run_cmd(8'h85, 8'h10, 8'h00, 8'h00, 8'h00, -1, 1'b0);
        run_cmd(8'h83, 8'h20, 8'h00, 8'h00, 8'h00, 2, 1'b0);

        obs_q.delete();
        send_byte(8'h83, ok, acc_c);
        send_byte(8'h50, ok, acc_c);
        send_byte(8'h01, ok, acc_c);
        rst = 1'b0;
        #1;
        check_outputs_zero("mid_write_reset");
        repeat (3) @(posedge fsm_clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge fsm_clk);
        #1;
        check("reset_no_strobe", 32'(obs_q.size()), 32'd0);
        run_cmd(8'h00, 8'h4E, 8'h00, 8'h00, 8'h00, -1, 1'b0);
        run_cmd(8'h00, 8'h50, 8'h00, 8'h00, 8'h00, -1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            h = (sel < 3) ? 8'h00 : (sel < 7) ? 8'(8'h80 + 8'($urandom_range(1, 3))) : 8'($urandom);
            a = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(140, 170)) : 8'($urandom);
            ns = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : -1;
            run_cmd(h, a, 8'($urandom), 8'($urandom), 8'($urandom), ns, ($urandom_range(0, 4) == 0));
        end

        check("strobe_rules", 32'(viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sb_reg_access_ctrl.md
# sb_reg_access_ctrl

Sideband register-access controller that sits directly upstream of the sideband register file. It consumes a byte stream of already-deframed register-access commands from the sideband receiver and decodes each one into `s_read`/`s_write` strobes, `s_address` and `s_data` for the register file. For reads it captures the 24-bit `sb_read` return. It then emits a byte-wide response (read data, write acknowledge, or error status) under a valid/ready handshake.

## Interface
- `TIMEOUT_CYC`, default 255: number of idle cycles allowed mid-command before the command is aborted. Range 1..65535.
- `REG_DEPTH`, default 157: number of implemented register addresses, 0..REG_DEPTH-1.
- `fsm_clk` in 1: the single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `cmd_byte` in 8: incoming command byte.
- `cmd_valid` in 1: `cmd_byte` is valid.
- `cmd_ready` out 1: a byte is accepted on an edge where `cmd_valid & cmd_ready`.
- `s_read` out 1: one-cycle read strobe to the register file.
- `s_write` out 1: one-cycle write strobe to the register file.
- `s_address` out 8: register address for `s_write`; holds the command address during `s_read`.
- `s_data` out 8: write data.
- `sb_read` in 24: register-file read return; valid the cycle after `s_read`.
- `rsp_data` out 8: response byte.
- `rsp_valid` out 1: response byte valid; held until accepted.
- `rsp_ready` in 1: downstream accepts on an edge where `rsp_valid & rsp_ready`.
- `rsp_last` out 1: marks the final byte of a response.

## Operation
- **Command format:**
  - Byte 0 is the header `{wr, 5'b0, len[1:0]}`.
  - Byte 1 is the address.
  - For a write, bytes 2..1+len are data.
  - A legal read header is exactly 0x00; `len` is ignored for reads and must be 0.
  - A legal write header is 0x81–0x83, giving 1–3 data bytes.
- **Error conditions.** The header is latched and the address byte is always consumed. An error is flagged if any of the following hold:
  - The reserved bits are nonzero.
  - The header is a write with `len`=0.
  - The header is a read with `len`≠0.
  - The last touched address (addr for reads, addr+len-1 for writes) is ≥ REG_DEPTH. The sum is computed in 9 bits, so there is no 8-bit wrap.
- **Error handling:**
  - No strobe is issued.
  - If the header is a legal write, its len data bytes are still consumed and discarded.
  - The response is a single byte 0xFF with `rsp_last`=1.
- **Writes:**
  - Each accepted data byte i (0-based) produces one `s_write` cycle with `s_address`=addr+i and `s_data`=byte.
  - The response is one byte equal to the header echo, with `rsp_last`=1.
- **Reads:**
  - One `s_read` cycle with `s_address`=addr.
  - `sb_read` is captured on the following cycle.
  - The response is 4 bytes: 0x00, `sb_read[7:0]`, `sb_read[15:8]`, `sb_read[23:16]`. `rsp_last` is set on the 4th byte.
- **States:**
  - IDLE → HDR_ADDR on header accept.
  - HDR_ADDR → WDATA (legal write or discarding write), RD_REQ (legal read) or RSP (other error) on address accept.
  - WDATA → WSTB on data accept when no error is flagged, or stays in WDATA (discarding) when an error is flagged; → RSP after the last data byte.
  - WSTB → WDATA or RSP.
  - RD_REQ → RD_CAP → RSP.
  - RSP → IDLE when the last byte is accepted.
- `cmd_ready` is 1 only in IDLE, HDR_ADDR and WDATA. It is 0 in WSTB, RD_REQ, RD_CAP and RSP, so exactly one command is in flight.
- **Timeout:**
  - A 16-bit counter clears on every accepted byte and counts in HDR_ADDR and WDATA while no byte is accepted.
  - On reaching TIMEOUT_CYC, the partial command is dropped without strobes and the 0xFF response is sent.

## Timing
- **Reset values:**
  - `s_read`, `s_write`, `s_address`, `s_data`, `rsp_data`, `rsp_valid` and `rsp_last` are all 0.
  - The state is IDLE, so `cmd_ready`=1.
  - The timeout counter is 0.
- **Write latency.** A data byte is accepted at edge k. `s_write`, `s_address` and `s_data` are valid during cycle k+1 only. After the final strobe, `rsp_valid` rises in cycle k+2.
- **Read latency.** The address is accepted at edge k. `s_read`=1 during cycle k+1, and `sb_read` is sampled at the end of cycle k+2. `rsp_valid` rises in cycle k+3.
- **Error latency.** For an error with no data to discard, `rsp_valid` rises the cycle after the address is accepted.
- **Strobes.** `s_read` and `s_write` are never high together, and never high for more than one consecutive cycle.
- **Response handshake.** `rsp_data`, `rsp_valid` and `rsp_last` stay stable while `rsp_valid & ~rsp_ready`. The next byte is presented in the cycle after acceptance. After the last byte is accepted, the block is in IDLE in the next cycle with `rsp_valid`=0.
- **Mid-operation reset.** Asserting `rst` during any state immediately clears all outputs, discards the partial command and any captured data, and leaves no pending strobe.

## Test plan
- **Read after reset.** Send 0x00, 0x4E. Require exactly one `s_read` cycle with `s_address`=0x4E. Require the response 0x00, 0x03, 0x33, 0x05, with `rsp_last` only on 0x05.
- **Multi-byte write.** Send 0x82, 0x55, 0x11, 0x22. Require `s_write` at (0x55, 0x11), then at (0x56, 0x22), and no other strobes. Require the single response 0x82 with `rsp_last`=1.
- **Out-of-range write.** Send 0x82, 0x9C, 0xAA, 0xBB; the last address 0x9D is ≥ 157. Require no `s_write`, all 4 bytes consumed, and the response 0xFF.
- **Timeout.** With TIMEOUT_CYC=8, send 0x81 and then hold `cmd_valid`=0. Require the 0xFF response after 8 idle cycles, then a following read (0x00, 0x4E) to complete normally.
- **Backpressure.** During a read response, hold `rsp_ready`=0 for 10 cycles. Require `rsp_data` and `rsp_valid` to stay stable, `cmd_ready` to stay 0, and no bytes to be lost once `rsp_ready` returns to 1.
- **Reset mid-write.** Assert `rst` after 0x83, 0x50, 0x01. Require all outputs to read 0 immediately and no further `s_write`. Require a subsequent 0x00, 0x4E read to return the reset values 0x03, 0x33, 0x05.
